if_fetch_ctrl: RTL and testbench
================================

// Module: if_fetch_ctrl
// PURPOSE
//  Sequences instruction fetch for the IF stage: owns the PC and drives the instruction memory req/gnt/rvalid handshake.
//  Buffers one fetched instruction for ID in a valid/ready IF/ID slot.
//  Handles the boot delay and branch/JAL redirects, killing stale in-flight responses.
//  Sits between instruction memory and id_stage.
// PARAMETERS
//  BOOT_CYCLES  2  cycles spent in BOOT before first fetch (>=1)
// PORTS
//  clk_i             in   1   clock
//  rst_ni            in   1   async active-low reset
//  fetch_en_i        in   1   allow new requests (sampled only before req is raised)
//  boot_addr_i       in   32  first fetch address, loaded in IDLE
//  instr_req_o       out  1   memory request
//  instr_addr_o      out  32  request address, word aligned
//  instr_gnt_i       in   1   request accepted
//  instr_rvalid_i    in   1   response valid
//  instr_rdata_i     in   32  response data
//  redirect_i        in   1   branch taken / JAL(R) target valid (1-cycle pulse)
//  redirect_addr_i   in   32  redirect target; bits [1:0] forced to 0
//  id_ready_i        in   1   ID consumes slot this cycle
//  instr_valid_id_o  out  1   slot valid
//  instr_rdata_id_o  out  32  slot instruction
//  pc_id_o           out  32  PC of slot instruction
//  fetch_busy_o      out  1   state is REQ or WAIT
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; pc_q=0, addr_q=0, kill_q=0, boot count=0.
//  slot_free = !instr_valid_id_o | id_ready_i. At most one outstanding request.
//  States:
//   IDLE:  1 cycle. pc_q<=boot_addr_i&~3. -> BOOT.
//   BOOT:  BOOT_CYCLES cycles, req=0. -> READY.
//          redirect_i and rvalid are ignored in IDLE and BOOT.
//   READY: req_o = fetch_en_i & slot_free & !redirect_i; addr_o=pc_q.
//          req&gnt -> WAIT; req&!gnt -> REQ with addr_q<=pc_q.
//   REQ:   req_o=1, addr_o=addr_q. Both are held stable until gnt; there is no abort.
//          gnt -> WAIT.
//   WAIT:  req=0. On rvalid: if kill_q, drop data and clear kill_q; else load slot.
//          Either case -> READY.
//  On gnt: out_pc_q<=addr_o; pc_q<=addr_o+4.
//   The add is 32-bit modulo, so 0xFFFFFFFC wraps to 0x0.
//  On rvalid (WAIT, !kill_q): slot<={rdata, out_pc_q}, valid=1 the next cycle.
//   Latency is gnt->rvalid plus 1 cycle to instr_valid_id_o.
//   Throughput is at most 1 instruction per 2 cycles.
//  Slot: valid clears when id_ready_i & valid and there is no load.
//   rdata and pc hold while valid & !id_ready_i.
//  Redirect (READY/REQ/WAIT):
//   - pc_q<=redirect_addr_i&~3; slot valid<=0 (flush). A redirect wins over a gnt-driven pc increment.
//   - In REQ (incl. gnt the same cycle) or WAIT: kill_q<=1, so the pending response is dropped.
//   - In WAIT with rvalid the same cycle: data is dropped, kill_q stays 0, -> READY.
//   - A redirect in READY suppresses req that cycle; the next req uses the new pc.
//  fetch_en_i low: READY issues nothing. REQ/WAIT complete normally.
//  Reset mid-operation: immediate return to IDLE. Any later rvalid is ignored (IDLE/BOOT).
//  Memory must not assert rvalid without a prior gnt. A protocol rvalid in READY/REQ is ignored.
// TESTING
//  1. boot_addr=0x80, fetch_en=1, gnt same cycle, rvalid +1:
//     first req at cycle 3 after reset release, addr 0x80; valid with pc_id=0x80; next req addr 0x84.
//  2. Slot full, id_ready=0 for 5 cycles -> req_o=0 throughout.
//     id_ready=1 -> req_o=1 in the same cycle, addr=pc+4.
//  3. gnt delayed 3 cycles -> addr_o stable. Redirect to 0x200 during REQ:
//     old rvalid is dropped (valid stays 0); next req addr=0x200.
//  4. Redirect in the same cycle as rvalid in WAIT -> no valid; next req=redirect addr.
//  5. pc=0xFFFFFFFC fetched -> next req addr 0x00000000.
//  6. rst_ni low while in WAIT -> all outputs 0; rvalid after release is ignored;
//     first req comes after the BOOT sequence, at boot_addr.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the PC, drives the instruction memory req/gnt/rvalid
// handshake and buffers one fetched instruction for ID in a valid/ready slot.
module if_fetch_ctrl #(
    parameter int BOOT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_en_i,
    input  logic [31:0] boot_addr_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    input  logic        id_ready_i,
    output logic        instr_valid_id_o,
    output logic [31:0] instr_rdata_id_o,
    output logic [31:0] pc_id_o,
    output logic        fetch_busy_o
);

    localparam int CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BOOT,
        S_READY,
        S_REQ,
        S_WAIT
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   boot_cnt_q, boot_cnt_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        out_pc_q, out_pc_d;
    logic               kill_q, kill_d;
    logic               valid_q, valid_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        pc_id_q, pc_id_d;

    logic               req_c;
    logic [31:0]        addr_c;
    logic               load_c;
    logic               redir_c;
    logic               slot_free_c;

    always_comb begin
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        out_pc_d    = out_pc_q;
        kill_d      = kill_q;
        valid_d     = valid_q;
        rdata_d     = rdata_q;
        pc_id_d     = pc_id_q;
        req_c       = 1'b0;
        addr_c      = pc_q;
        load_c      = 1'b0;
        slot_free_c = !valid_q | id_ready_i;
        redir_c     = redirect_i & ((state_q == S_READY) | (state_q == S_REQ) | (state_q == S_WAIT));

        case (state_q)
            S_IDLE: begin
                pc_d       = boot_addr_i & ~32'h3;
                boot_cnt_d = '0;
                state_d    = S_BOOT;
            end
            S_BOOT: begin
                if (boot_cnt_q == BOOT_LAST) begin
                    boot_cnt_d = '0;
                    state_d    = S_READY;
                end else begin
                    boot_cnt_d = boot_cnt_q + 1'b1;
                end
            end
            S_READY: begin
                req_c = fetch_en_i & slot_free_c & !redirect_i;
                if (req_c) begin
                    if (instr_gnt_i) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                        addr_d  = pc_q;
                    end
                end
            end
            S_REQ: begin
                // Request is committed once raised: address held until granted.
                req_c  = 1'b1;
                addr_c = addr_q;
                if (instr_gnt_i) begin
                    state_d = S_WAIT;
                end
                if (redirect_i) begin
                    kill_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (instr_rvalid_i) begin
                    state_d = S_READY;
                    kill_d  = 1'b0;
                    load_c  = !kill_q & !redirect_i;
                end else if (redirect_i) begin
                    kill_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A pending kill means pc_q already holds a redirect target; keep it.
        if (req_c & instr_gnt_i) begin
            out_pc_d = addr_c;
            if (!kill_q) begin
                pc_d = addr_c + 32'd4;
            end
        end
        if (redir_c) begin
            pc_d = redirect_addr_i & ~32'h3;
        end

        if (valid_q & id_ready_i) begin
            valid_d = 1'b0;
        end
        if (load_c) begin
            valid_d = 1'b1;
            rdata_d = instr_rdata_i;
            pc_id_d = out_pc_q;
        end
        if (redir_c) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            boot_cnt_q <= '0;
            pc_q       <= '0;
            addr_q     <= '0;
            out_pc_q   <= '0;
            kill_q     <= 1'b0;
            valid_q    <= 1'b0;
            rdata_q    <= '0;
            pc_id_q    <= '0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            out_pc_q   <= out_pc_d;
            kill_q     <= kill_d;
            valid_q    <= valid_d;
            rdata_q    <= rdata_d;
            pc_id_q    <= pc_id_d;
        end
    end

    assign instr_req_o      = req_c;
    assign instr_addr_o     = addr_c;
    assign instr_valid_id_o = valid_q;
    assign instr_rdata_id_o = rdata_q;
    assign pc_id_o          = pc_id_q;
    assign fetch_busy_o     = (state_q == S_REQ) | (state_q == S_WAIT);

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios plus a randomized run checked against a
// program-order model of the delivered instruction stream.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] boot_addr;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        id_ready;
    logic        valid_id;
    logic [31:0] rdata_id;
    logic [31:0] pc_id;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_fetch_ctrl #(.BOOT_CYCLES(2)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .fetch_en_i       (fetch_en),
        .boot_addr_i      (boot_addr),
        .instr_req_o      (req),
        .instr_addr_o     (addr),
        .instr_gnt_i      (gnt),
        .instr_rvalid_i   (rvalid),
        .instr_rdata_i    (rdata),
        .redirect_i       (redirect),
        .redirect_addr_i  (redirect_addr),
        .id_ready_i       (id_ready),
        .instr_valid_id_o (valid_id),
        .instr_rdata_id_o (rdata_id),
        .pc_id_o          (pc_id),
        .fetch_busy_o     (busy)
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [31:0] boot);
        rst_n         = 1'b0;
        fetch_en      = 1'b0;
        gnt           = 1'b0;
        rvalid        = 1'b0;
        rdata         = '0;
        redirect      = 1'b0;
        redirect_addr = '0;
        id_ready      = 1'b0;
        boot_addr     = boot;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        fetch_en = 1'b1;
        gnt      = 1'b1;
        rvalid   = 1'b1;
        rdata    = 32'hFFFF_FFFF;
        redirect = 1'b1;
        redirect_addr = 32'h1234_5678;
        id_ready = 1'b1;
        boot_addr = 32'h80;
        #2;
        total++;
        if ({req, addr, valid_id, rdata_id, pc_id, busy} !== 98'd0) begin
            bad++;
            $display("FAIL reset_outputs: got req=%b addr=%h v=%b rd=%h pc=%h busy=%b want all 0",
                     req, addr, valid_id, rdata_id, pc_id, busy);
        end
        tick();
        total++;
        if ({req, addr, valid_id, rdata_id, pc_id, busy} !== 98'd0) begin
            bad++;
            $display("FAIL reset_held: got req=%b addr=%h v=%b rd=%h pc=%h busy=%b want all 0",
                     req, addr, valid_id, rdata_id, pc_id, busy);
        end
    endtask

    task automatic test_boot_fetch();
        apply_reset(32'h80);
        fetch_en = 1'b1;
        id_ready = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            tick();
            total++;
            if (req !== 1'b0) begin
                bad++;
                $display("FAIL boot_no_req: cycle %0d got req=%b want 0", c, req);
            end
        end
        tick();
        total++;
        if ({req, addr} !== {1'b1, 32'h80}) begin
            bad++;
            $display("FAIL first_req: got req=%b addr=%h want req=1 addr=00000080", req, addr);
        end
        gnt = 1'b1;
        tick();
        gnt    = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'h1111_2222;
        #1;
        total++;
        if ({req, busy} !== 2'b01) begin
            bad++;
            $display("FAIL wait_state: got req=%b busy=%b want req=0 busy=1", req, busy);
        end
        tick();
        rvalid = 1'b0;
        #1;
        total++;
        if ({valid_id, pc_id, rdata_id} !== {1'b1, 32'h80, 32'h1111_2222}) begin
            bad++;
            $display("FAIL first_slot: got v=%b pc=%h rd=%h want v=1 pc=00000080 rd=11112222",
                     valid_id, pc_id, rdata_id);
        end
        total++;
        if ({req, addr} !== {1'b1, 32'h84}) begin
            bad++;
            $display("FAIL second_req: got req=%b addr=%h want req=1 addr=00000084", req, addr);
        end
    endtask

    task automatic test_slot_backpressure();
        id_ready = 1'b0;
        #1;
        for (int c = 0; c < 5; c++) begin
            total++;
            if (req !== 1'b0) begin
                bad++;
                $display("FAIL full_no_req: cycle %0d got req=%b want 0", c, req);
            end
            tick();
        end
        total++;
        if ({valid_id, pc_id} !== {1'b1, 32'h80}) begin
            bad++;
            $display("FAIL slot_hold: got v=%b pc=%h want v=1 pc=00000080", valid_id, pc_id);
        end
        id_ready = 1'b1;
        #1;
        total++;
        if ({req, addr} !== {1'b1, 32'h84}) begin
            bad++;
            $display("FAIL ready_req: got req=%b addr=%h want req=1 addr=00000084", req, addr);
        end
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        #1;
        total++;
        if (valid_id !== 1'b0) begin
            bad++;
            $display("FAIL slot_consumed: got v=%b want 0", valid_id);
        end
        rvalid = 1'b1;
        rdata  = 32'h3333_4444;
        tick();
        rvalid = 1'b0;
        #1;
        total++;
        if ({valid_id, pc_id, rdata_id} !== {1'b1, 32'h84, 32'h3333_4444}) begin
            bad++;
            $display("FAIL second_slot: got v=%b pc=%h rd=%h want v=1 pc=00000084 rd=33334444",
                     valid_id, pc_id, rdata_id);
        end
    endtask

    task automatic test_redirect_in_req();
        #1;
        total++;
        if ({req, addr} !== {1'b1, 32'h88}) begin
            bad++;
            $display("FAIL pre_req: got req=%b addr=%h want req=1 addr=00000088", req, addr);
        end
        tick();
        for (int c = 0; c < 3; c++) begin
            redirect      = (c == 1);
            redirect_addr = 32'h0000_0203;
            #1;
            total++;
            if ({req, addr, busy} !== {1'b1, 32'h88, 1'b1}) begin
                bad++;
                $display("FAIL req_hold: cycle %0d got req=%b addr=%h busy=%b want req=1 addr=00000088 busy=1",
                         c, req, addr, busy);
            end
            if (c == 2) gnt = 1'b1;
            tick();
            redirect = 1'b0;
        end
        gnt    = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'hDEAD_BEEF;
        tick();
        rvalid = 1'b0;
        #1;
        total++;
        if (valid_id !== 1'b0) begin
            bad++;
            $display("FAIL killed_resp: got v=%b want 0", valid_id);
        end
        total++;
        if ({req, addr} !== {1'b1, 32'h200}) begin
            bad++;
            $display("FAIL redirect_req: got req=%b addr=%h want req=1 addr=00000200", req, addr);
        end
    endtask

    task automatic test_redirect_with_rvalid();
        gnt = 1'b1;
        tick();
        gnt           = 1'b0;
        rvalid        = 1'b1;
        rdata         = 32'hCAFE_0001;
        redirect      = 1'b1;
        redirect_addr = 32'h300;
        tick();
        rvalid   = 1'b0;
        redirect = 1'b0;
        #1;
        total++;
        if (valid_id !== 1'b0) begin
            bad++;
            $display("FAIL same_cycle_drop: got v=%b want 0", valid_id);
        end
        total++;
        if ({req, addr} !== {1'b1, 32'h300}) begin
            bad++;
            $display("FAIL same_cycle_req: got req=%b addr=%h want req=1 addr=00000300", req, addr);
        end
        gnt = 1'b1;
        tick();
        gnt    = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'h4444_5555;
        tick();
        rvalid = 1'b0;
        #1;
        total++;
        if ({valid_id, pc_id, rdata_id} !== {1'b1, 32'h300, 32'h4444_5555}) begin
            bad++;
            $display("FAIL no_stale_kill: got v=%b pc=%h rd=%h want v=1 pc=00000300 rd=44445555",
                     valid_id, pc_id, rdata_id);
        end
    endtask

    task automatic test_pc_wrap();
        redirect      = 1'b1;
        redirect_addr = 32'hFFFF_FFFF;
        #1;
        total++;
        if (req !== 1'b0) begin
            bad++;
            $display("FAIL ready_redirect_sup: got req=%b want 0", req);
        end
        tick();
        redirect = 1'b0;
        #1;
        total++;
        if ({req, addr, valid_id} !== {1'b1, 32'hFFFF_FFFC, 1'b0}) begin
            bad++;
            $display("FAIL wrap_req: got req=%b addr=%h v=%b want req=1 addr=fffffffc v=0",
                     req, addr, valid_id);
        end
        gnt = 1'b1;
        tick();
        gnt    = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'h5555_6666;
        tick();
        rvalid = 1'b0;
        #1;
        total++;
        if ({valid_id, pc_id} !== {1'b1, 32'hFFFF_FFFC}) begin
            bad++;
            $display("FAIL wrap_slot: got v=%b pc=%h want v=1 pc=fffffffc", valid_id, pc_id);
        end
        total++;
        if ({req, addr} !== {1'b1, 32'h0}) begin
            bad++;
            $display("FAIL wrap_next: got req=%b addr=%h want req=1 addr=00000000", req, addr);
        end
    endtask

    task automatic test_reset_in_wait();
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        #1;
        total++;
        if ({req, busy} !== 2'b01) begin
            bad++;
            $display("FAIL pre_reset_wait: got req=%b busy=%b want req=0 busy=1", req, busy);
        end
        rst_n     = 1'b0;
        boot_addr = 32'h0000_1002;
        rvalid    = 1'b1;
        rdata     = 32'h7777_8888;
        #1;
        total++;
        if ({req, addr, valid_id, rdata_id, pc_id, busy} !== 98'd0) begin
            bad++;
            $display("FAIL midreset_outputs: got req=%b addr=%h v=%b rd=%h pc=%h busy=%b want all 0",
                     req, addr, valid_id, rdata_id, pc_id, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            tick();
            total++;
            if ({req, valid_id} !== 2'b00) begin
                bad++;
                $display("FAIL reboot_idle: cycle %0d got req=%b v=%b want 0 0", c, req, valid_id);
            end
        end
        tick();
        total++;
        if ({req, addr, valid_id} !== {1'b1, 32'h1000, 1'b0}) begin
            bad++;
            $display("FAIL reboot_req: got req=%b addr=%h v=%b want req=1 addr=00001000 v=0",
                     req, addr, valid_id);
        end
        rvalid = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] resp_addr;
        logic [31:0] prev_addr;
        logic [31:0] cur_addr;
        logic        pend;
        logic        prev_hold;
        int          dly;
        int          delivered;
        exp_pc    = $urandom & ~32'h3;
        apply_reset(exp_pc);
        fetch_en  = 1'b1;
        repeat (3) tick();
        pend      = 1'b0;
        prev_hold = 1'b0;
        prev_addr = '0;
        resp_addr = '0;
        dly       = 0;
        delivered = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            redirect      = ($urandom_range(0, 15) == 0);
            redirect_addr = $urandom;
            fetch_en      = ($urandom_range(0, 7) != 0);
            id_ready      = ($urandom_range(0, 2) != 0);
            gnt           = 1'b0;
            rvalid        = pend && (dly == 0);
            rdata         = rvalid ? mem_data(resp_addr) : $urandom;
            #1;
            gnt      = req && !pend && ($urandom_range(0, 2) != 0);
            cur_addr = addr;
            if (pend) begin
                total++;
                if (req !== 1'b0) begin
                    bad++;
                    $display("FAIL rnd_outstanding: cycle %0d got req=%b want 0", cyc, req);
                end
            end
            if (prev_hold) begin
                total++;
                if ({req, addr} !== {1'b1, prev_addr}) begin
                    bad++;
                    $display("FAIL rnd_req_stable: cycle %0d got req=%b addr=%h want req=1 addr=%h",
                             cyc, req, addr, prev_addr);
                end
            end
            if (redirect) begin
                exp_pc = redirect_addr & ~32'h3;
            end else if (valid_id && id_ready) begin
                total++;
                if (pc_id !== exp_pc) begin
                    bad++;
                    $display("FAIL rnd_pc_order: cycle %0d got pc=%h want %h", cyc, pc_id, exp_pc);
                end
                total++;
                if (rdata_id !== mem_data(pc_id)) begin
                    bad++;
                    $display("FAIL rnd_rdata: cycle %0d got %h want %h", cyc, rdata_id, mem_data(pc_id));
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            prev_hold = req && !gnt;
            prev_addr = cur_addr;
            @(posedge clk);
            if (gnt) begin
                pend      = 1'b1;
                resp_addr = cur_addr;
                dly       = $urandom_range(0, 2);
            end else if (rvalid) begin
                pend = 1'b0;
            end else if (pend) begin
                dly--;
            end
            #1;
        end
        total++;
        if (delivered < 50) begin
            bad++;
            $display("FAIL rnd_progress: got %0d deliveries want at least 50", delivered);
        end
        redirect = 1'b0;
        gnt      = 1'b0;
        rvalid   = 1'b0;
    endtask

    initial begin
        test_reset();
        test_boot_fetch();
        test_slot_backpressure();
        test_redirect_in_req();
        test_redirect_with_rvalid();
        test_pc_wrap();
        test_reset_in_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
